// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for DIV/DIVU.
// Holds the EX stage via alu_stall until quotient/remainder are valid.
module div_iter #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reg_stall,
  input  logic                 reg_flush,
  input  logic                 start,
  input  logic                 sign,
  input  logic [DIV_WIDTH-1:0] source_a,
  input  logic [DIV_WIDTH-1:0] source_b,
  output logic                 alu_stall,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder
);

  localparam int W  = DIV_WIDTH;
  localparam int CW = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0] cnt_q;
  logic [W-1:0]  dvd_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  a_raw_q;
  logic          sign_q;
  logic          a_neg_q;
  logic          b_neg_q;
  logic          zero_q;

  logic          a_neg;
  logic          b_neg;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic          accept;
  logic          busy;
  logic          last;
  logic [W:0]    r_shift;
  logic [W+1:0]  diff;
  logic          q_bit;
  logic [W-1:0]  rem_nxt;
  logic          neg_q;
  logic          neg_r;

  assign a_neg = sign & source_a[W-1];
  assign b_neg = sign & source_b[W-1];
  assign a_mag = a_neg ? -source_a : source_a;
  assign b_mag = b_neg ? -source_b : source_b;

  assign accept = (state_q == S_IDLE) & start & ~reg_flush;
  assign busy   = (state_q == S_BUSY) & ~reg_flush;
  assign last   = (cnt_q == CW'(DIV_WIDTH - 1));

  assign r_shift = {rem_q, dvd_q[W-1]};
  assign diff    = {1'b0, r_shift} - {2'b00, dvs_q};
  assign q_bit   = ~diff[W+1];
  assign rem_nxt = q_bit ? diff[W-1:0] : r_shift[W-1:0];

  // next state, stall request and done strobe
  always_comb begin
    state_d   = state_q;
    alu_stall = 1'b0;
    done      = 1'b0;
    if (reg_flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          alu_stall = start;
          if (start) state_d = S_BUSY;
        end
        S_BUSY: begin
          alu_stall = 1'b1;
          if (last) state_d = S_DONE;
        end
        S_DONE: begin
          done = 1'b1;
          if (!reg_stall) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // iteration counter, restarted on accept and on flush
  always_ff @(posedge clk) begin
    if (rst || reg_flush || accept) cnt_q <= '0;
    else if (busy)                  cnt_q <= cnt_q + 1'b1;
  end

  // operand latch and one restoring step per busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      a_raw_q <= '0;
      sign_q  <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      dvd_q   <= a_mag;
      dvs_q   <= b_mag;
      rem_q   <= '0;
      a_raw_q <= source_a;
      sign_q  <= sign;
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
      zero_q  <= (source_b == '0);
    end else if (busy) begin
      dvd_q <= {dvd_q[W-2:0], q_bit};
      rem_q <= rem_nxt;
    end
  end

  assign neg_q = sign_q & (a_neg_q ^ b_neg_q);
  assign neg_r = sign_q & a_neg_q;

  assign quotient  = zero_q ? '1 :
                     (neg_q ? -dvd_q : dvd_q);
  assign remainder = zero_q ? a_raw_q :
                     (neg_r ? -rem_q : rem_q);

endmodule
